// File: rtl/ser_arb_pkg.sv
// Shared types and constants for the serializing two-way arbiter.
// Frame length depends on SER_ARB_PARITY_EN (adds one even-parity bit).
package ser_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int W_DEF   = 4;
  localparam int GAP_DEF = 1;

  function automatic int frame_len(input int w);
`ifdef SER_ARB_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

endpackage

// File: rtl/ser_arb_ctrl_rr_arb2.sv
// Two-request round-robin arbiter; one-hot grant, pointer remembers the last winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic last;  // 1 when req1 was granted last; resets so req0 wins the first tie

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)      last <= 1'b1;
    else if (upd) last <= gnt[1];

endmodule

// File: rtl/ser_arb_ctrl.sv
// Arbitrates two parallel requesters and shifts the winner's word out LSB first.
// Optional SER_ARB_PARITY_EN appends an even-parity bit to each frame.
module ser_arb_ctrl
  import ser_arb_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int GAP = GAP_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  input  logic [W-1:0] req0_data,
  input  logic [W-1:0] req1_data,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         sout_first,
  output logic         sout_last,
  output logic         src,
  output logic         busy
);

  localparam int FL      = frame_len(W);
  localparam int CNT_MAX = (FL > GAP) ? FL : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int GAP_M1  = (GAP > 0) ? GAP - 1 : 0;

  state_t        state, state_d;
  logic [FL-1:0] sreg, sreg_d, load_word;
  logic [CW-1:0] cnt, cnt_d;
  logic          src_q, src_d;
  logic [1:0]    gnt;
  logic          hs;
  logic [W-1:0]  win_data;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1_valid, req0_valid}),
    .upd (hs),
    .gnt (gnt)
  );

  assign win_data = gnt[1] ? req1_data : req0_data;
`ifdef SER_ARB_PARITY_EN
  assign load_word = {^win_data, win_data};
`else
  assign load_word = win_data;
`endif

  // cnt counts frame bits in SHIFT and idle cycles in GAP
  always_comb begin
    state_d    = state;
    sreg_d     = sreg;
    cnt_d      = cnt;
    src_d      = src_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    hs         = 1'b0;
    case (state)
      ST_IDLE: begin
        req0_ready = gnt[0] & ~rst;
        req1_ready = gnt[1] & ~rst;
        hs         = req0_ready | req1_ready;
        if (hs) begin
          sreg_d  = load_word;
          src_d   = gnt[1];
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sreg_d = sreg >> 1;
        cnt_d  = cnt + 1'b1;
        if (cnt == CW'(FL - 1)) begin
          cnt_d   = '0;
          state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CW'(GAP_M1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      src_q <= 1'b0;
    end else begin
      state <= state_d;
      sreg  <= sreg_d;
      cnt   <= cnt_d;
      src_q <= src_d;
    end

  assign busy       = (state != ST_IDLE);
  assign sout_valid = (state == ST_SHIFT);
  assign sout       = sout_valid & sreg[0];
  assign sout_first = sout_valid & (cnt == '0);
  assign sout_last  = sout_valid & (cnt == CW'(FL - 1));
  assign src        = src_q;

endmodule

// File: doc/ser_arb_ctrl.md
SER_ARB_CTRL -- requirements
Module: ser_arb_ctrl

Interface
REQ-001 SHALL have parameter W, default 4, meaning word width in bits (W >= 2).
REQ-002 SHALL have parameter GAP, default 1, meaning idle cycles inserted between words (0..15).
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester has a word pending.
REQ-006 SHALL have ports req0_data / req1_data  input  W  parallel word from each requester.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  word accepted this cycle (grant).
REQ-008 SHALL have port sout  output  1  serial data, LSB first.
REQ-009 SHALL have port sout_valid  output  1  sout carries a frame bit this cycle.
REQ-010 SHALL have ports sout_first / sout_last  output  1  first and last bit of a frame.
REQ-011 SHALL have port src  output  1  requester index owning the current frame.
REQ-012 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, GAP.
REQ-014 IDLE: readyN SHALL be combinational, asserted only for the arbitration winner among valid requesters, at most one high.
REQ-015 Arbitration SHALL be round-robin: on both valid, the requester not granted last wins; single valid always wins.
REQ-016 Handshake (validN & readyN at edge) SHALL load the shift register with reqN_data, set src=N, clear the bit counter, enter SHIFT.
REQ-017 SHIFT: sout SHALL equal shift-register bit 0, sout_valid=1; each cycle the register shifts right with 0 fill, counter increments.
REQ-018 First data bit SHALL appear on the cycle after the handshake (latency 1); sout_first=1 only on that cycle.
REQ-019 On the final frame bit sout_last=1; next state SHALL be GAP if GAP>0, else IDLE.
REQ-020 GAP: sout_valid=0, sout=0, for exactly GAP cycles, then IDLE.
REQ-021 readyN SHALL be 0 in SHIFT and GAP; valid held during those states is served on return to IDLE.
REQ-022 With GAP=0 and pending requests, back-to-back frames SHALL be separated by exactly one IDLE cycle.
REQ-023 Data changes on reqN_data while not handshaking SHALL not affect the frame in flight.

Reset
REQ-024 rst high SHALL force IDLE immediately, regardless of clock, even mid-frame; the frame is aborted, not resumed.
REQ-025 Reset values: sout=0, sout_valid=0, sout_first=0, sout_last=0, src=0, busy=0, readyN=0 while rst high, shift register 0, counter 0.
REQ-026 Round-robin pointer SHALL reset so req0 wins the first tie.

Configuration
REQ-027 Macro SER_ARB_PARITY_EN defined: frame SHALL be W data bits plus one even-parity bit (XOR of the word), sout_last on the parity bit; frame length W+1.
REQ-028 Macro undefined: frame SHALL be W data bits, sout_last on data bit W-1; no parity logic present.

Structure
REQ-029 Package ser_arb_pkg SHALL hold the state enum type, the frame-length constant function and parameter defaults.
REQ-030 Round-robin logic SHALL be a sub-module rr_arb2 (2 requests, last-grant pointer, one-hot grant output).

Verification
REQ-031 W=4, GAP=1, req0 data 4'b1011 alone -> sout 1,1,0,1 on the 4 cycles after handshake, first/last flags on bits 1/4, src=0, then 1 GAP cycle.
REQ-032 Both valid after reset, data0=4'b0001, data1=4'b1000 -> req0 granted first, req1 granted on the next IDLE; src 0 then 1.
REQ-033 Both held valid continuously for 4 frames -> grants alternate 0,1,0,1; never two readys in one cycle.
REQ-034 rst asserted asynchronously during bit 2 of a frame -> all outputs 0 before the next edge, busy=0, next grant to req0 on tie.
REQ-035 SER_ARB_PARITY_EN, data 4'b0111 -> 5-bit frame 1,1,1,0,1 with sout_last on the fifth bit.
REQ-036 GAP=0, req1 valid continuously -> frames of W valid cycles separated by exactly one IDLE cycle.
